tilemap_writer: RTL

Read-modify-write engine that updates the nibble-packed tile map in the display BRAM. Game logic (player, cars, level resets) issues cell-level or row-level tile commands. This block turns them into BRAM read/write cycles that are interleaved with the VGA renderer through a grant signal. It is the write side of the tile-map interface that the renderer reads.

---
 rtl/tilemap_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tilemap_writer.sv
// ============================================================================
//  Module   : tilemap_writer
//  Purpose  : Read-modify-write engine for the nibble-packed display tile map,
//             sharing the BRAM port with the renderer through a grant signal.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tilemap_writer #(
    parameter int unsigned MAP_COLS   = 20,
    parameter int unsigned MAP_ROWS   = 15,
    parameter int unsigned ROW_STRIDE = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic        i_Clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_op,
    input  logic [4:0]  i_cmd_x,
    input  logic [3:0]  i_cmd_y,
    input  logic [3:0]  i_cmd_tile,
    output logic        o_cmd_err,
    input  logic        i_bram_grant,
    output logic [10:0] o_bram_addr,
    output logic        o_bram_re,
    output logic        o_bram_we,
    output logic [15:0] o_bram_wdata,
    input  logic [15:0] i_bram_rdata,
    output logic        o_busy
);

    localparam int unsigned C_FILL_WORDS = (MAP_COLS + 3) / 4;
    localparam logic [2:0]  C_LAST_IDX   = 3'(C_FILL_WORDS - 1);
    localparam logic [10:0] C_BASE       = 11'(BASE_ADDR);
    localparam logic [10:0] C_STRIDE     = 11'(ROW_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_FILL  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_ready;
    logic        r_busy;
    logic        r_err;
    logic [10:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_tile;
    logic [1:0]  r_nib;
    logic [2:0]  r_idx;

    logic        w_accept;
    logic        w_in_range;
    logic [10:0] w_row_base;
    logic [10:0] w_cell_addr;
    logic [15:0] w_merged;

    assign o_cmd_ready = r_ready & ~i_reset;
    assign w_accept    = i_cmd_valid & o_cmd_ready;

    // FILL ignores x, so only SET is range-checked on the column.
    assign w_in_range  = ({28'd0, i_cmd_y} < MAP_ROWS) &&
                         (i_cmd_op || ({27'd0, i_cmd_x} < MAP_COLS));

    // 11-bit arithmetic gives the modulo-2048 wrap for free.
    assign w_row_base  = C_BASE + C_STRIDE * {7'd0, i_cmd_y};
    assign w_cell_addr = w_row_base + {8'd0, i_cmd_x[4:2]};

    always_comb begin
        w_merged = i_bram_rdata;
        case (r_nib)
            2'd0:    w_merged[15:12] = r_tile;
            2'd1:    w_merged[11:8]  = r_tile;
            2'd2:    w_merged[7:4]   = r_tile;
            default: w_merged[3:0]   = r_tile;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_in_range) w_next = i_cmd_op ? S_FILL : S_READ;
            S_READ:  if (i_bram_grant) w_next = S_WAIT;
            S_WAIT:  w_next = S_WRITE;
            S_WRITE: if (i_bram_grant) w_next = S_IDLE;
            S_FILL:  if (i_bram_grant && (r_idx == C_LAST_IDX)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tile  <= '0;
            r_nib   <= '0;
            r_idx   <= '0;
        end else begin
            r_ready <= (w_next == S_IDLE);
            r_busy  <= (w_next != S_IDLE);
            r_err   <= w_accept && !w_in_range;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_in_range) begin
                        r_tile <= i_cmd_tile;
                        r_nib  <= i_cmd_x[1:0];
                        r_idx  <= '0;
                        if (i_cmd_op) begin
                            r_addr  <= w_row_base;
                            r_wdata <= {4{i_cmd_tile}};
                        end else begin
                            r_addr  <= w_cell_addr;
                        end
                    end
                end
                S_WAIT:  r_wdata <= w_merged;
                S_FILL: begin
                    if (i_bram_grant) begin
                        r_idx  <= r_idx + 3'd1;
                        r_addr <= r_addr + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are qualified by grant in the cycle itself so the renderer owns the port otherwise.
    assign o_bram_re    = (r_state == S_READ) && i_bram_grant && !i_reset;
    assign o_bram_we    = ((r_state == S_WRITE) || (r_state == S_FILL)) && i_bram_grant && !i_reset;
    assign o_bram_addr  = r_addr;
    assign o_bram_wdata = r_wdata;
    assign o_cmd_err    = r_err;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire
